// File: rtl/recorder_ctrl.sv
// Audio recorder sequencer: key pulses drive record/play/pause state,
// a whole-second elapsed-time counter and the playback-rate setting.
module recorder_ctrl #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KEY_PLAY,
    input  logic       KEY_STOP,
    input  logic       KEY_REC,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    input  logic       SLOW_SW,
    input  logic       MEM_FULL,
    input  logic       PLAY_END,
    output logic [2:0] STATE,
    output logic       REC_EN,
    output logic       PLAY_EN,
    output logic       IS_PAUSE,
    output logic       IS_SLOW,
    output logic       ADDR_CLR,
    output logic [4:0] OUT_TIME,
    output logic [2:0] OUT_RATE,
    output logic [4:0] REC_LEN
);

    localparam int ACC_W = $clog2(7 * CLK_HZ);
    localparam logic [ACC_W-1:0] HZ_M1 = ACC_W'(CLK_HZ - 1);
    localparam logic [ACC_W:0]   HZ_W  = (ACC_W + 1)'(CLK_HZ);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RECORD     = 3'd1,
        REC_PAUSE  = 3'd2,
        PLAY       = 3'd3,
        PLAY_PAUSE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_adv, acc_nxt, slow_top;
    logic [ACC_W:0]   fast_sum;
    logic             tick, restart, addr_clr_nxt;
    logic             key_stop, key_play, key_rec;
    logic [4:0]       time_nxt, rec_len_nxt;
    logic [2:0]       rate_nxt;

    assign STATE    = state;
    assign key_stop = KEY_STOP;
    assign key_play = KEY_PLAY & ~KEY_STOP;
    assign key_rec  = KEY_REC & ~KEY_PLAY & ~KEY_STOP;

    // Second-tick accumulator; only RECORD and PLAY advance it.
    always_comb begin
        tick     = 1'b0;
        acc_adv  = acc;
        fast_sum = {1'b0, acc} + (ACC_W + 1)'(OUT_RATE);
        slow_top = ACC_W'(CLK_HZ * int'(OUT_RATE) - 1);
        case (state)
            RECORD: begin
                if (acc == HZ_M1) begin
                    tick    = 1'b1;
                    acc_adv = '0;
                end else begin
                    acc_adv = acc + ACC_W'(1);
                end
            end
            PLAY: begin
                if (!IS_SLOW) begin
                    if (fast_sum >= HZ_W) begin
                        tick    = 1'b1;
                        acc_adv = ACC_W'(fast_sum - HZ_W);
                    end else begin
                        acc_adv = fast_sum[ACC_W-1:0];
                    end
                end else if (acc == slow_top) begin
                    tick    = 1'b1;
                    acc_adv = '0;
                end else begin
                    acc_adv = acc + ACC_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rate_nxt = OUT_RATE;
        if (KEY_UP && !KEY_DOWN && OUT_RATE != 3'd7)
            rate_nxt = OUT_RATE + 3'd1;
        else if (KEY_DOWN && !KEY_UP && OUT_RATE != 3'd1)
            rate_nxt = OUT_RATE - 3'd1;
    end

    // Next state; the exit to IDLE always outranks other keys and ticks.
    always_comb begin
        state_nxt    = state;
        time_nxt     = OUT_TIME;
        rec_len_nxt  = REC_LEN;
        addr_clr_nxt = 1'b0;
        restart      = 1'b0;
        case (state)
            IDLE: begin
                if (key_rec) begin
                    state_nxt    = RECORD;
                    addr_clr_nxt = 1'b1;
                    rec_len_nxt  = 5'd0;
                    restart      = 1'b1;
                end else if (key_play && REC_LEN != 5'd0) begin
                    state_nxt    = PLAY;
                    addr_clr_nxt = 1'b1;
                    restart      = 1'b1;
                end
            end
            RECORD: begin
                if (key_stop || MEM_FULL) begin
                    state_nxt   = IDLE;
                    rec_len_nxt = OUT_TIME;
                end else if (tick && OUT_TIME == 5'd31) begin
                    state_nxt   = IDLE;
                    rec_len_nxt = 5'd31;
                end else begin
                    if (tick)
                        time_nxt = OUT_TIME + 5'd1;
                    if (key_play)
                        state_nxt = REC_PAUSE;
                end
            end
            REC_PAUSE: begin
                if (key_stop) begin
                    state_nxt   = IDLE;
                    rec_len_nxt = OUT_TIME;
                end else if (key_play) begin
                    state_nxt = RECORD;
                end
            end
            PLAY: begin
                if (key_stop || PLAY_END) begin
                    state_nxt = IDLE;
                end else begin
                    if (tick && OUT_TIME < REC_LEN)
                        time_nxt = OUT_TIME + 5'd1;
                    if (key_play)
                        state_nxt = PLAY_PAUSE;
                end
            end
            PLAY_PAUSE: begin
                if (key_stop)
                    state_nxt = IDLE;
                else if (key_play)
                    state_nxt = PLAY;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE)
            time_nxt = 5'd0;
        if (restart)
            time_nxt = 5'd0;

        acc_nxt = acc_adv;
        if (restart || rate_nxt != OUT_RATE || SLOW_SW != IS_SLOW)
            acc_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            OUT_TIME <= 5'd0;
            REC_LEN  <= 5'd0;
            OUT_RATE <= 3'd1;
            IS_SLOW  <= 1'b0;
            ADDR_CLR <= 1'b0;
            REC_EN   <= 1'b0;
            PLAY_EN  <= 1'b0;
            IS_PAUSE <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            OUT_TIME <= time_nxt;
            REC_LEN  <= rec_len_nxt;
            OUT_RATE <= rate_nxt;
            IS_SLOW  <= SLOW_SW;
            ADDR_CLR <= addr_clr_nxt;
            REC_EN   <= (state_nxt == RECORD);
            PLAY_EN  <= (state_nxt == PLAY);
            IS_PAUSE <= (state_nxt == REC_PAUSE) || (state_nxt == PLAY_PAUSE);
        end
    end

endmodule

// File: doc/recorder_ctrl.md
# recorder_ctrl

Top-level sequencer for the audio recorder: turns debounced key pulses and mode switches into the record/play/pause state of the audio datapath. It runs the elapsed-time counter in whole seconds and holds the playback-rate setting. It drives the seven-segment display inputs: time 0–31, rate, pause, record and slow flags. It sits between the key debouncers and both the SRAM recorder/player datapath and the display block.

## Interface
Parameters:
- CLK_HZ, 50000000, clock cycles per real-time second. Must be ≥ 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- KEY_PLAY  in  1  one-cycle pulse; play/pause toggle
- KEY_STOP  in  1  one-cycle pulse; stop
- KEY_REC  in  1  one-cycle pulse; start recording
- KEY_UP  in  1  one-cycle pulse; rate +1
- KEY_DOWN  in  1  one-cycle pulse; rate −1
- SLOW_SW  in  1  level; 1 = slow playback (÷rate), 0 = fast playback (×rate)
- MEM_FULL  in  1  level; recorder reached last SRAM address
- PLAY_END  in  1  level; player reached end of recorded data
- STATE  out  3  current state code
- REC_EN  out  1  datapath record enable
- PLAY_EN  out  1  datapath play enable
- IS_PAUSE  out  1  paused (record or play)
- IS_SLOW  out  1  registered copy of SLOW_SW
- ADDR_CLR  out  1  one-cycle pulse; datapath resets its SRAM address
- OUT_TIME  out  5  elapsed seconds, 0–31
- OUT_RATE  out  3  rate factor, 1–7
- REC_LEN  out  5  length of last recording in seconds

## Operation
- States: IDLE=0, RECORD=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4. Codes 5–7 are illegal and go to IDLE on the next clock.
- Key priority in one cycle: STOP > PLAY > REC. Lower-priority keys in the same cycle are ignored.
- IDLE:
  - KEY_REC → RECORD, with ADDR_CLR pulse, OUT_TIME=0, REC_LEN=0, acc=0.
  - KEY_PLAY with REC_LEN>0 → PLAY, with ADDR_CLR pulse, OUT_TIME=0, acc=0.
  - KEY_PLAY with REC_LEN=0 is ignored.
- RECORD:
  - KEY_PLAY → REC_PAUSE.
  - KEY_STOP or MEM_FULL → IDLE, REC_LEN=OUT_TIME.
  - Second tick: OUT_TIME+1. A tick arriving with OUT_TIME=31 goes to IDLE with REC_LEN=31; OUT_TIME never wraps.
- REC_PAUSE: KEY_PLAY → RECORD. KEY_STOP → IDLE with REC_LEN=OUT_TIME.
- PLAY:
  - KEY_PLAY → PLAY_PAUSE.
  - KEY_STOP or PLAY_END → IDLE.
  - Second tick: OUT_TIME+1, saturating at REC_LEN.
- PLAY_PAUSE: KEY_PLAY → PLAY. KEY_STOP → IDLE.
- On every entry to IDLE, OUT_TIME=0. REC_LEN is updated only as stated above.
- Second tick: accumulator acc, ⌈log2(7·CLK_HZ)⌉ bits. It advances only in RECORD and PLAY and holds in all other states.
  - RECORD: acc+=1. At acc=CLK_HZ−1: tick, acc=0.
  - PLAY, fast (IS_SLOW=0): acc+=OUT_RATE. If result ≥ CLK_HZ: tick, acc−=CLK_HZ.
  - PLAY, slow (IS_SLOW=1): acc+=1. At acc=CLK_HZ·OUT_RATE−1: tick, acc=0.
- Rate:
  - KEY_UP: OUT_RATE+1, saturating at 7.
  - KEY_DOWN: OUT_RATE−1, saturating at 1.
  - Both in the same cycle: no change.
  - Rate keys act in every state.
- acc clears to 0 in the cycle OUT_RATE or IS_SLOW changes.
- REC_EN=1 only in RECORD. PLAY_EN=1 only in PLAY. IS_PAUSE=1 in REC_PAUSE or PLAY_PAUSE.

## Timing
- All outputs are registered.
- A key pulse sampled at edge n gives new STATE and flags at edge n+1.
- ADDR_CLR is high for exactly the first cycle of the new RECORD/PLAY state.
- A tick and OUT_TIME+1 occur on the same edge.
- MEM_FULL and PLAY_END are sampled every cycle with latency 1. A key and MEM_FULL/PLAY_END in the same cycle: the exit to IDLE wins.
- IS_SLOW follows SLOW_SW with 1-cycle delay.
- Reset, including mid-operation, takes effect at the next edge:
  - STATE=IDLE, REC_LEN=0, OUT_TIME=0, OUT_RATE=1, acc=0.
  - REC_EN=0, PLAY_EN=0, IS_PAUSE=0, ADDR_CLR=0, IS_SLOW=0.
- Keys are ignored in the reset cycle.

## Test plan
(CLK_HZ=10)
- Reset mid-RECORD → next cycle STATE=0, OUT_TIME=0, OUT_RATE=1, REC_LEN=0, all flags 0.
- KEY_REC, then 35 cycles, then KEY_STOP:
  - ADDR_CLR is high for one cycle.
  - OUT_TIME steps 1, 2, 3 at cycles 10, 20, 30.
  - After stop: STATE=IDLE, REC_LEN=3, OUT_TIME=0.
- KEY_REC, hold 330 cycles:
  - OUT_TIME reaches 31.
  - The next tick (cycle 320) returns to IDLE with REC_LEN=31.
  - Repeat with MEM_FULL at cycle 55 → IDLE, REC_LEN=5.
- REC_LEN=3, fast, rate 2 (one KEY_UP), KEY_PLAY:
  - Ticks every 5 cycles; OUT_TIME saturates at 3.
  - PLAY_END → IDLE.
- REC_LEN=3, slow, rate 3:
  - Ticks every 30 cycles.
  - KEY_PLAY at cycle 15 → PLAY_PAUSE, acc held for 40 cycles.
  - Resume → tick 15 cycles later.
- KEY_STOP+KEY_PLAY in RECORD → IDLE.
- KEY_UP+KEY_DOWN → rate unchanged.
- 8× KEY_UP → rate 7; 8× KEY_DOWN → rate 1.
- KEY_PLAY in IDLE with REC_LEN=0 → no state change.
